// File: rtl/gf_pkg.sv
// GF(2^m) field constants, arithmetic helpers and the Forney FSM state type
// shared by the RS decoder back end.
package gf_pkg;
  localparam int SYMB_WIDTH = 8;
  localparam int T_LEN      = 8;
  localparam int SYMB_NUM   = 1 << SYMB_WIDTH;

  typedef logic [SYMB_WIDTH-1:0] symb_t;

  // x^8+x^4+x^3+x^2+1 with the x^m term implied by the shift-out
  localparam symb_t PRIM_POLY = symb_t'(32'h1D);

  typedef enum logic [2:0] {IDLE, SLOT, EVAL, SKIP, DIV, DONE} forney_state_t;

  function automatic symb_t gf_mult(symb_t a, symb_t b);
    symb_t r;
    r = '0;
    for (int i = SYMB_WIDTH-1; i >= 0; i--) begin
      r = {r[SYMB_WIDTH-2:0], 1'b0} ^ (r[SYMB_WIDTH-1] ? PRIM_POLY : '0);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  // alpha^e by square-and-multiply; the alpha^(2^j) chain folds to constants
  function automatic symb_t alpha_to_symb(symb_t e);
    symb_t r, a;
    r = symb_t'(1);
    a = symb_t'(2);
    for (int j = 0; j < SYMB_WIDTH; j++) begin
      if (e[j]) r = gf_mult(r, a);
      a = gf_mult(a, a);
    end
    return r;
  endfunction

  // x^(2^m-2) = prod x^(2^j), j=1..m-1; maps 0 to 0
  function automatic symb_t gf_inv(symb_t x);
    symb_t s, r;
    s = x;
    r = symb_t'(1);
    for (int j = 1; j < SYMB_WIDTH; j++) begin
      s = gf_mult(s, s);
      r = gf_mult(r, s);
    end
    return r;
  endfunction
endpackage

// File: rtl/rs_forney_seq_horner.sv
// One Horner polynomial evaluator: load seeds the top coefficient, each step
// does acc = acc*x + c.
module gf_horner_eval
  import gf_pkg::*;
#(
  parameter int WIDTH = SYMB_WIDTH
) (
  input  logic             aclk,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] coef_in,
  input  logic [WIDTH-1:0] x_in,
  output logic [WIDTH-1:0] acc
);
  logic [WIDTH-1:0] acc_q;

  always_ff @(posedge aclk) begin
    if (load)      acc_q <= coef_in;
    else if (step) acc_q <= gf_mult(acc_q, x_in) ^ coef_in;
  end

  assign acc = acc_q;
endmodule

// File: rtl/rs_forney_seq.sv
// Sequential Forney stage: e = Omega(X^-1) / Lambda'(X^-1) per flagged slot,
// two shared Horner evaluators walked over the slots one at a time.
module rs_forney_seq
  import gf_pkg::*;
(
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [T_LEN:0][SYMB_WIDTH-1:0]   error_locator,
  input  logic [T_LEN-1:0][SYMB_WIDTH-1:0] error_evaluator,
  input  logic [T_LEN-1:0][SYMB_WIDTH-1:0] error_positions,
  input  logic [T_LEN-1:0]                 error_positions_mask,
  input  logic                             error_positions_vld,
  output logic                             in_ready,
  output logic [T_LEN-1:0][SYMB_WIDTH-1:0] error_values,
  output logic [T_LEN-1:0][SYMB_WIDTH-1:0] error_values_pos,
  output logic [T_LEN-1:0]                 error_values_mask,
  output logic                             error_values_vld,
  output logic                             forney_err
);
  localparam int IW = $clog2(T_LEN+1);
  localparam int SW = $clog2(T_LEN);

  forney_state_t                    state_q;
  logic [IW-1:0]                    idx_q;
  logic [SW-1:0]                    cnt_q;
  symb_t                            xinv_q;
  logic [T_LEN:0][SYMB_WIDTH-1:0]   lambda_q;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] omega_q, pos_q, vals_q;
  logic [T_LEN-1:0]                 mask_q;
  logic                             in_ready_q, vld_q, err_q;

  logic [SW-1:0] slot, csel;
  logic [IW-1:0] lsel;
  logic          last_slot, hz_load, hz_step;
  symb_t         om_coef, ld_coef, om_acc, ld_acc, xinv_d, val_d;

  assign slot      = idx_q[SW-1:0];
  assign last_slot = (idx_q == IW'(T_LEN));

  // SLOT doubles as the first Horner step (seed with the top coefficient),
  // and resolves masked slots on its own, so there is no separate SKIP cycle.
  always_comb begin
    csel    = (state_q == SLOT) ? SW'(T_LEN-1) : cnt_q;
    lsel    = IW'(csel) + IW'(1);
    om_coef = omega_q[csel];
    ld_coef = csel[0] ? '0 : lambda_q[lsel];
    hz_load = (state_q == SLOT) && !last_slot && mask_q[slot];
    hz_step = (state_q == EVAL);
    // alpha has order 2^m-1, so ~p == -p mod (2^m-1); p=0 gives alpha^(2^m-1)=1
    xinv_d  = alpha_to_symb(~pos_q[slot]);
    val_d   = (ld_acc == '0) ? '0 : gf_mult(om_acc, gf_inv(ld_acc));
  end

  gf_horner_eval #(.WIDTH(SYMB_WIDTH)) u_omega (
    .aclk(aclk), .load(hz_load), .step(hz_step),
    .coef_in(om_coef), .x_in(xinv_q), .acc(om_acc)
  );

  gf_horner_eval #(.WIDTH(SYMB_WIDTH)) u_dlambda (
    .aclk(aclk), .load(hz_load), .step(hz_step),
    .coef_in(ld_coef), .x_in(xinv_q), .acc(ld_acc)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      xinv_q     <= '0;
      lambda_q   <= '0;
      omega_q    <= '0;
      pos_q      <= '0;
      mask_q     <= '0;
      vals_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (error_positions_vld && in_ready_q) begin
          lambda_q   <= error_locator;
          omega_q    <= error_evaluator;
          pos_q      <= error_positions;
          mask_q     <= error_positions_mask;
          vals_q     <= '0;
          err_q      <= 1'b0;
          idx_q      <= '0;
          in_ready_q <= 1'b0;
          state_q    <= SLOT;
        end
        SLOT: begin
          if (last_slot) begin
            vld_q   <= 1'b1;
            state_q <= DONE;
          end else if (!mask_q[slot]) begin
            idx_q <= idx_q + IW'(1);
          end else begin
            xinv_q  <= xinv_d;
            cnt_q   <= SW'(T_LEN-2);
            state_q <= EVAL;
          end
        end
        EVAL: begin
          if (cnt_q == '0) state_q <= DIV;
          else             cnt_q   <= cnt_q - SW'(1);
        end
        DIV: begin
          if (ld_acc == '0) err_q <= 1'b1;
          vals_q[slot] <= val_d;
          idx_q        <= idx_q + IW'(1);
          state_q      <= SLOT;
        end
        DONE: begin
          vld_q      <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready          = in_ready_q;
  assign error_values      = vals_q;
  assign error_values_pos  = pos_q;
  assign error_values_mask = mask_q;
  assign error_values_vld  = vld_q;
  assign forney_err        = err_q;
endmodule

// File: tb/tb_rs_forney_seq.sv
// Bench for rs_forney_seq: directed scenarios plus random RS error patterns
// checked by log/antilog field arithmetic and codeword correction.
module tb_rs_forney_seq;
  localparam int M  = 8;
  localparam int T  = 8;
  localparam int N  = 255;
  localparam int NR = 600;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [T:0][M-1:0]   loc;
  logic [T-1:0][M-1:0] ev, pos, vals, vpos;
  logic [T-1:0]        msk, vmsk;
  logic                vld_in, in_ready, vvld, ferr;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_t[0:509];
  int log_t[0:255];

  always #5 aclk = ~aclk;

  rs_forney_seq dut (
    .aclk(aclk), .aresetn(aresetn),
    .error_locator(loc), .error_evaluator(ev),
    .error_positions(pos), .error_positions_mask(msk),
    .error_positions_vld(vld_in), .in_ready(in_ready),
    .error_values(vals), .error_values_pos(vpos),
    .error_values_mask(vmsk), .error_values_vld(vvld),
    .forney_err(ferr)
  );

  function automatic int gmul(int a, int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[log_t[a] + log_t[b]];
  endfunction

  function automatic int gpow(int a, int e);
    if (a == 0) return (e == 0) ? 1 : 0;
    return exp_t[(log_t[a] * e) % N];
  endfunction

  function automatic int ginv(int a);
    return exp_t[(N - log_t[a]) % N];
  endfunction

  // Direct polynomial evaluation of the Forney formula plus expected latency
  task automatic model(output logic [T-1:0][M-1:0] ev_out, output bit err_out, output int cost);
    int xi, om, ld;
    ev_out = '0; err_out = 1'b0; cost = 1;
    for (int s = 0; s < T; s++) begin
      if (!msk[s]) begin
        cost += 1;
      end else begin
        cost += T + 1;
        xi = exp_t[(N - int'(pos[s])) % N];
        om = 0; ld = 0;
        for (int k = 0; k < T; k++) om ^= gmul(int'(ev[k]), gpow(xi, k));
        for (int k = 1; k <= T; k += 2) ld ^= gmul(int'(loc[k]), gpow(xi, k - 1));
        if (ld == 0) err_out = 1'b1;
        else ev_out[s] = 8'(gmul(om, ginv(ld)));
      end
    end
  endtask

  task automatic rand_inputs();
    for (int k = 0; k <= T; k++) loc[k] = 8'($urandom);
    for (int k = 0; k < T; k++) begin
      ev[k]  = 8'($urandom);
      pos[k] = 8'($urandom_range(0, N - 1));
    end
    msk = 8'($urandom);
  endtask

  task automatic start_job();
    @(negedge aclk);
    vld_in = 1'b1;
    @(posedge aclk);
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge aclk);
      if (k == 0) vld_in = 1'b0;
      if (vvld) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    vld_in = 1'b0;
    rand_inputs();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    n_tests++;
    if ({vals, vpos, vmsk, vvld, ferr} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", {vals, vpos, vmsk, vvld, ferr});
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    n_tests++;
    if (in_ready !== 1'b1 || vvld !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: in_ready %b vld %b required 1 0", in_ready, vvld);
    end
  endtask

  task automatic test_single_error();
    logic [T-1:0][M-1:0] expv;
    bit experr;
    int cost, lat;
    rand_inputs();
    loc = '0; loc[0] = 8'h01; loc[1] = 8'h01;
    ev = '0; ev[0] = 8'h5A;
    pos[0] = 8'h00; msk = 8'h01;
    model(expv, experr, cost);
    start_job();
    wait_done(200, lat);
    n_tests++;
    if (lat !== cost) begin
      n_fail++; $display("FAIL single_latency: got %0d required %0d", lat, cost);
    end
    n_tests++;
    if (vals[0] !== 8'h5A) begin
      n_fail++; $display("FAIL single_value0: got %h required 5a", vals[0]);
    end
    n_tests++;
    if (vals !== expv || ferr !== 1'b0) begin
      n_fail++; $display("FAIL single_values: got %h err %b required %h err 0", vals, ferr, expv);
    end
    n_tests++;
    if (vpos !== pos || vmsk !== msk) begin
      n_fail++; $display("FAIL single_copies: got %h/%h required %h/%h", vpos, vmsk, pos, msk);
    end
    @(negedge aclk);
    n_tests++;
    if (vvld !== 1'b0) begin
      n_fail++; $display("FAIL single_pulse_width: vld got %b required 0", vvld);
    end
  endtask

  task automatic test_zero_deriv();
    int lat;
    rand_inputs();
    loc = '0; loc[0] = 8'h01; loc[2] = 8'h01;
    msk = 8'h01;
    start_job();
    wait_done(200, lat);
    n_tests++;
    if (lat < 0) begin
      n_fail++; $display("FAIL zero_deriv_vld: got no pulse required one");
    end
    n_tests++;
    if (vals !== '0 || ferr !== 1'b1) begin
      n_fail++; $display("FAIL zero_deriv: got %h err %b required 0 err 1", vals, ferr);
    end
  endtask

  task automatic test_all_masked();
    int lat;
    rand_inputs();
    msk = '0;
    start_job();
    wait_done(200, lat);
    n_tests++;
    if (lat !== 9) begin
      n_fail++; $display("FAIL masked_latency: got %0d required 9", lat);
    end
    n_tests++;
    if (vals !== '0 || ferr !== 1'b0) begin
      n_fail++; $display("FAIL masked_values: got %h err %b required 0 err 0", vals, ferr);
    end
  endtask

  task automatic test_back_to_back();
    logic [T-1:0][M-1:0] expA, expB, locA_ev;
    logic [T:0][M-1:0] bl, al;
    logic [T-1:0][M-1:0] bev, bpos;
    logic [T-1:0] bmsk;
    bit errA, errB, drop;
    int cA, cB;
    int pulses[$];
    int rdy[$];
    rand_inputs();
    bl = loc; bev = ev; bpos = pos; bmsk = msk;
    model(expB, errB, cB);
    rand_inputs();
    al = loc; locA_ev = ev;
    model(expA, errA, cA);
    @(negedge aclk);
    vld_in = 1'b1;
    @(posedge aclk);
    drop = 1'b0;
    for (int k = 0; k < cA + cB + 3; k++) begin
      @(negedge aclk);
      if (k == 0) begin
        loc = bl; ev = bev; pos = bpos; msk = bmsk;
      end
      if (drop) vld_in = 1'b0;
      if (in_ready) begin
        rdy.push_back(k);
        drop = 1'b1;
      end
      if (vvld) begin
        n_tests++;
        if (pulses.size() == 0 && (vals !== expA || ferr !== errA)) begin
          n_fail++; $display("FAIL b2b_jobA: got %h err %b required %h err %b", vals, ferr, expA, errA);
        end else if (pulses.size() == 1 && (vals !== expB || ferr !== errB)) begin
          n_fail++; $display("FAIL b2b_jobB: got %h err %b required %h err %b", vals, ferr, expB, errB);
        end
        pulses.push_back(k);
      end
    end
    vld_in = 1'b0;
    n_tests++;
    if (pulses.size() != 2 || pulses[0] != cA || pulses[1] != cA + 2 + cB) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d pulses first at %0d required at %0d and %0d",
                         pulses.size(), (pulses.size() > 0) ? pulses[0] : -1, cA, cA + 2 + cB);
    end
    n_tests++;
    if (rdy.size() != 1 || rdy[0] != cA + 1) begin
      n_fail++; $display("FAIL b2b_in_ready: got %0d ready cycles first at %0d required one at %0d",
                         rdy.size(), (rdy.size() > 0) ? rdy[0] : -1, cA + 1);
    end
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_reset_mid_eval();
    int pulses[$];
    rand_inputs();
    msk = '1;
    start_job();
    repeat (4) @(negedge aclk);
    vld_in = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    n_tests++;
    if ({vals, vpos, vmsk, vvld, ferr} !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_outputs: got %h rdy %b required 0 rdy 1",
                         {vals, vpos, vmsk, vvld, ferr}, in_ready);
    end
    aresetn = 1'b1;
    rand_inputs();
    msk = '0;
    vld_in = 1'b1;
    @(posedge aclk);
    for (int k = 0; k < 90; k++) begin
      @(negedge aclk);
      if (k == 0) vld_in = 1'b0;
      if (vvld) pulses.push_back(k);
    end
    n_tests++;
    if (pulses.size() != 1 || pulses[0] != 9) begin
      n_fail++; $display("FAIL midreset_pulses: got %0d pulses first at %0d required one at 9",
                         pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
    end
    n_tests++;
    if (vals !== '0 || ferr !== 1'b0) begin
      n_fail++; $display("FAIL midreset_newjob: got %h err %b required 0 err 0", vals, ferr);
    end
  endtask

  task automatic test_random();
    int cw[N];
    int rx[N];
    int ep[T];
    int evl[T];
    int lam[T+1];
    int syn[2*T];
    bit [N-1:0] used;
    int nerr, p, s, x, om, lat, bad, cost;
    for (int it = 0; it < NR; it++) begin
      rand_inputs();
      nerr = $urandom_range(1, T);
      used = '0; msk = '0;
      for (int j = 0; j < nerr; j++) begin
        do p = $urandom_range(0, N - 1); while (used[p]);
        used[p] = 1'b1;
        ep[j] = p;
        evl[j] = $urandom_range(1, N);
        do s = $urandom_range(0, T - 1); while (msk[s]);
        msk[s] = 1'b1;
        pos[s] = 8'(p);
      end
      for (int k = 0; k <= T; k++) lam[k] = 0;
      lam[0] = 1;
      for (int j = 0; j < nerr; j++) begin
        x = exp_t[ep[j]];
        for (int k = T; k >= 1; k--) lam[k] ^= gmul(lam[k-1], x);
      end
      for (int i = 0; i < 2*T; i++) begin
        syn[i] = 0;
        for (int j = 0; j < nerr; j++) syn[i] ^= gmul(evl[j], gpow(exp_t[ep[j]], i + 1));
      end
      for (int k = 0; k <= T; k++) loc[k] = 8'(lam[k]);
      for (int k = 0; k < T; k++) begin
        om = 0;
        for (int i = 0; i <= k; i++) om ^= gmul(syn[i], lam[k-i]);
        ev[k] = 8'(om);
      end
      for (int i = 0; i < N; i++) begin
        cw[i] = $urandom_range(0, N);
        rx[i] = cw[i];
      end
      for (int j = 0; j < nerr; j++) rx[ep[j]] ^= evl[j];
      cost = 1 + nerr * (T + 1) + (T - nerr);
      start_job();
      wait_done(200, lat);
      for (int k = 0; k < T; k++) if (vmsk[k]) rx[int'(vpos[k])] ^= int'(vals[k]);
      bad = 0;
      for (int i = 0; i < N; i++) if (rx[i] != cw[i]) bad++;
      n_tests++;
      if (bad != 0) begin
        n_fail++; $display("FAIL rand_correct it %0d: got %0d bad symbols required 0", it, bad);
      end
      n_tests++;
      if (lat != cost || ferr !== 1'b0) begin
        n_fail++; $display("FAIL rand_timing it %0d: got lat %0d err %b required %0d err 0", it, lat, ferr, cost);
      end
    end
  endtask

  initial begin
    int v;
    v = 1;
    for (int i = 0; i < N; i++) begin
      exp_t[i] = v;
      exp_t[i + N] = v;
      log_t[v] = i;
      v = v << 1;
      if (v & 32'h100) v ^= 32'h11D;
    end
    log_t[0] = 0;
    vld_in = 1'b0;
    loc = '0; ev = '0; pos = '0; msk = '0;
    test_reset();
    test_single_error();
    test_zero_deriv();
    test_all_masked();
    test_back_to_back();
    test_reset_mid_eval();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
